// File: rtl/pc_pkg.sv
// Shared types and helpers for the program-counter sequencer: the decoded
// next-PC source and the wrapping sequential increment.
package pc_pkg;

  // Widest address the helper function supports; callers cast in and out.
  localparam int unsigned PC_MAX_W = 32;

  typedef enum logic [2:0] {
    PC_SEQ,
    PC_JUMP,
    PC_CALL,
    PC_RET,
    PC_HOLD
  } pc_src_e;

  // Sequential successor: anything at or beyond the last address wraps to 0.
  function automatic logic [PC_MAX_W-1:0] wrap_inc(
    input logic [PC_MAX_W-1:0] addr,
    input logic [PC_MAX_W-1:0] last
  );
    wrap_inc = (addr >= last) ? '0 : addr + PC_MAX_W'(1);
  endfunction

endpackage

// File: rtl/pc_seq_unit_ras.sv
// Return-address stack: LIFO storage plus an occupancy count. The parent only
// issues push when not full and pop when not empty.
module ras_stack #(
  parameter int unsigned W     = 5,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clock,
  input  logic         clear_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] top,
  output logic         full,
  output logic         empty
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [CNT_W-1:0] count_q, count_d;
  logic [W-1:0]     mem_q [DEPTH];
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] top_idx;

  assign wr_idx  = IDX_W'(count_q);
  assign top_idx = IDX_W'(count_q - CNT_W'(1));

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!clear_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Storage needs no reset: entries above the count are never read.
  always_ff @(posedge clock) begin
    if (clear_n && push) begin
      mem_q[wr_idx] <= push_data;
    end
  end

  assign top   = mem_q[top_idx];
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/pc_seq_unit.sv
// Program counter with stall, absolute/relative jumps, call/return through a
// return-address stack, and a programmable sequential wrap limit.
module pc_seq_unit
  import pc_pkg::*;
#(
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned LAST_ADDR  = 19,
  parameter int unsigned RESET_ADDR = 0,
  parameter int unsigned RAS_DEPTH  = 4
) (
  input  logic              clock,
  input  logic              clear_n,
  input  logic              stall,
  input  logic              jump_en,
  input  logic              jump_rel,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              call_en,
  input  logic              ret_en,
  output logic [ADDR_W-1:0] instr_addr,
  output logic              ras_full,
  output logic              ras_empty,
  output logic              ras_overflow,
  output logic              ras_underflow
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic [ADDR_W-1:0] seq_addr;
  logic [ADDR_W-1:0] tgt_addr;
  logic [ADDR_W-1:0] ras_top;
  logic              ras_push;
  logic              ras_pop;
  pc_src_e           src;

  assign seq_addr = ADDR_W'(wrap_inc(PC_MAX_W'(pc_q), PC_MAX_W'(LAST_ADDR)));
  // Same-width addition gives the sign-extended offset modulo 2^ADDR_W.
  assign tgt_addr = jump_rel ? (pc_q + jump_target) : jump_target;

  always_comb begin
    src = PC_SEQ;
    if (stall) begin
      src = PC_HOLD;
    end else if (ret_en) begin
      src = PC_RET;
    end else if (call_en) begin
      src = PC_CALL;
    end else if (jump_en) begin
      src = PC_JUMP;
    end
  end

  assign ras_push = (src == PC_CALL) && !ras_full;
  assign ras_pop  = (src == PC_RET) && !ras_empty;

  always_comb begin
    pc_d  = seq_addr;
    ovf_d = ovf_q;
    unf_d = unf_q;
    case (src)
      PC_HOLD: pc_d = pc_q;
      PC_RET: begin
        pc_d = ras_empty ? seq_addr : ras_top;
        if (ras_empty) unf_d = 1'b1;
      end
      PC_CALL: begin
        pc_d = tgt_addr;
        if (ras_full) ovf_d = 1'b1;
      end
      PC_JUMP: pc_d = tgt_addr;
      default: pc_d = seq_addr;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!clear_n) begin
      pc_q  <= ADDR_W'(RESET_ADDR);
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  ras_stack #(
    .W     (ADDR_W),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clock     (clock),
    .clear_n   (clear_n),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (seq_addr),
    .top       (ras_top),
    .full      (ras_full),
    .empty     (ras_empty)
  );

  assign instr_addr    = pc_q;
  assign ras_overflow  = ovf_q;
  assign ras_underflow = unf_q;

endmodule

// File: tb/tb_pc_seq_unit.sv
// Directed vector bench for pc_seq_unit with default parameters: each row
// drives one cycle of inputs and lists the expected registered outputs.
module tb_pc_seq_unit;

  logic       clock = 1'b0;
  logic       clear_n;
  logic       stall;
  logic       jump_en;
  logic       jump_rel;
  logic [4:0] jump_target;
  logic       call_en;
  logic       ret_en;
  logic [4:0] instr_addr;
  logic       ras_full;
  logic       ras_empty;
  logic       ras_overflow;
  logic       ras_underflow;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    string      name;
    logic       clr_n;
    logic       stall;
    logic       je;
    logic       jr;
    logic [4:0] tgt;
    logic       ce;
    logic       re;
    logic [4:0] addr;
    logic       full;
    logic       empty;
    logic       ovf;
    logic       unf;
  } vec_t;

  vec_t vq[$];

  always #5 clock = ~clock;

  pc_seq_unit dut (
    .clock         (clock),
    .clear_n       (clear_n),
    .stall         (stall),
    .jump_en       (jump_en),
    .jump_rel      (jump_rel),
    .jump_target   (jump_target),
    .call_en       (call_en),
    .ret_en        (ret_en),
    .instr_addr    (instr_addr),
    .ras_full      (ras_full),
    .ras_empty     (ras_empty),
    .ras_overflow  (ras_overflow),
    .ras_underflow (ras_underflow)
  );

  task automatic v(input string name, input logic clr_n, input logic st,
                   input logic je, input logic jr, input logic [4:0] tgt,
                   input logic ce, input logic re, input logic [4:0] addr,
                   input logic full, input logic empty, input logic ovf,
                   input logic unf);
    vec_t r;
    r.name = name; r.clr_n = clr_n; r.stall = st; r.je = je; r.jr = jr;
    r.tgt = tgt; r.ce = ce; r.re = re; r.addr = addr; r.full = full;
    r.empty = empty; r.ovf = ovf; r.unf = unf;
    vq.push_back(r);
  endtask

  task automatic check(input string name, input logic [4:0] addr,
                       input logic full, input logic empty, input logic ovf,
                       input logic unf);
    n_vec++;
    if (instr_addr !== addr || ras_full !== full || ras_empty !== empty ||
        ras_overflow !== ovf || ras_underflow !== unf) begin
      n_miss++;
      $display("FAIL %s #%0d: got addr=%0d full=%b empty=%b ovf=%b unf=%b, want addr=%0d full=%b empty=%b ovf=%b unf=%b",
               name, n_vec, instr_addr, ras_full, ras_empty, ras_overflow,
               ras_underflow, addr, full, empty, ovf, unf);
    end else begin
      $display("vec %0d %s addr=%0d full=%b empty=%b ovf=%b unf=%b ok",
               n_vec, name, instr_addr, ras_full, ras_empty, ras_overflow,
               ras_underflow);
    end
  endtask

  initial begin
    clear_n = 1'b0; stall = 1'b0; jump_en = 1'b0; jump_rel = 1'b0;
    jump_target = '0; call_en = 1'b0; ret_en = 1'b0;

    // Reset, free run across the wrap, then a mid-run clear.
    v("reset",    0,0,0,0,5'd0, 0,0, 5'd0, 0,1,0,0);
    for (int i = 1; i <= 21; i++) v("free", 1,0,0,0,5'd0, 0,0, 5'(i % 20), 0,1,0,0);
    for (int i = 2; i <= 10; i++) v("seq",  1,0,0,0,5'd0, 0,0, 5'(i),      0,1,0,0);
    v("clr_mid",  0,0,0,0,5'd0, 0,0, 5'd0, 0,1,0,0);
    // Jumps: absolute, negative relative, relative past the wrap limit.
    for (int i = 1; i <= 5; i++) v("seq", 1,0,0,0,5'd0, 0,0, 5'(i), 0,1,0,0);
    v("jmp_abs",     1,0,1,0,5'd12,     0,0, 5'd12, 0,1,0,0);
    v("jmp_rel_neg", 1,0,1,1,5'b11101,  0,0, 5'd9,  0,1,0,0);
    v("jmp_abs19",   1,0,1,0,5'd19,     0,0, 5'd19, 0,1,0,0);
    v("jmp_rel_pos", 1,0,1,1,5'd2,      0,0, 5'd21, 0,1,0,0);
    v("seq_above",   1,0,0,0,5'd0,      0,0, 5'd0,  0,1,0,0);
    // Single call/return, and a call from the last address pushing 0.
    for (int i = 1; i <= 3; i++) v("seq", 1,0,0,0,5'd0, 0,0, 5'(i), 0,1,0,0);
    v("call",        1,0,0,0,5'd10, 1,0, 5'd10, 0,0,0,0);
    v("seq",         1,0,0,0,5'd0,  0,0, 5'd11, 0,0,0,0);
    v("seq",         1,0,0,0,5'd0,  0,0, 5'd12, 0,0,0,0);
    v("ret",         1,0,0,0,5'd0,  0,1, 5'd4,  0,1,0,0);
    v("jmp19",       1,0,1,0,5'd19, 0,0, 5'd19, 0,1,0,0);
    v("call_last",   1,0,0,0,5'd2,  1,0, 5'd2,  0,0,0,0);
    v("ret_wrap",    1,0,0,0,5'd0,  0,1, 5'd0,  0,1,0,0);
    // Nested calls to overflow, then unwind to underflow.
    v("call1",       1,0,0,0,5'd5,  1,0, 5'd5,  0,0,0,0);
    v("call2",       1,0,0,0,5'd8,  1,0, 5'd8,  0,0,0,0);
    v("call3",       1,0,0,0,5'd11, 1,0, 5'd11, 0,0,0,0);
    v("call4",       1,0,0,0,5'd14, 1,0, 5'd14, 1,0,0,0);
    v("call5_ovf",   1,0,0,0,5'd17, 1,0, 5'd17, 1,0,1,0);
    v("ret4",        1,0,0,0,5'd0,  0,1, 5'd12, 0,0,1,0);
    v("ret3",        1,0,0,0,5'd0,  0,1, 5'd9,  0,0,1,0);
    v("ret2",        1,0,0,0,5'd0,  0,1, 5'd6,  0,0,1,0);
    v("ret1",        1,0,0,0,5'd0,  0,1, 5'd1,  0,1,1,0);
    v("ret_unf",     1,0,0,0,5'd0,  0,1, 5'd2,  0,1,1,1);
    v("sticky",      1,0,0,0,5'd0,  0,0, 5'd3,  0,1,1,1);
    // Stall with every request asserted holds everything.
    v("call7",       1,0,0,0,5'd7,  1,0, 5'd7,  0,0,1,1);
    for (int i = 0; i < 3; i++) v("stall", 1,1,1,0,5'd15, 1,1, 5'd7, 0,0,1,1);
    v("unstall",     1,0,0,0,5'd0,  0,0, 5'd8,  0,0,1,1);
    // ret beats call/jump; call beats jump.
    v("jmp6",        1,0,1,0,5'd6,  0,0, 5'd6,  0,0,1,1);
    v("call20",      1,0,0,0,5'd20, 1,0, 5'd20, 0,0,1,1);
    v("ret_call",    1,0,1,0,5'd3,  1,1, 5'd7,  0,0,1,1);
    v("ret_after",   1,0,0,0,5'd0,  0,1, 5'd4,  0,1,1,1);
    v("call_jump",   1,0,1,0,5'd10, 1,0, 5'd10, 0,0,1,1);
    v("ret_cj",      1,0,0,0,5'd0,  0,1, 5'd5,  0,1,1,1);
    // Clear wipes sticky flags, and overrides stall and call.
    v("clr_flags",   0,0,0,0,5'd0,  0,0, 5'd0,  0,1,0,0);
    v("call9",       1,0,0,0,5'd9,  1,0, 5'd9,  0,0,0,0);
    v("clr_stall",   0,1,1,0,5'd4,  1,1, 5'd0,  0,1,0,0);
    v("seq_post",    1,0,0,0,5'd0,  0,0, 5'd1,  0,1,0,0);

    foreach (vq[i]) begin
      clear_n = vq[i].clr_n; stall = vq[i].stall; jump_en = vq[i].je;
      jump_rel = vq[i].jr; jump_target = vq[i].tgt; call_en = vq[i].ce;
      ret_en = vq[i].re;
      @(posedge clock);
      #1;
      check(vq[i].name, vq[i].addr, vq[i].full, vq[i].empty, vq[i].ovf, vq[i].unf);
    end

    // A jump request must not reach instr_addr before the clock edge.
    jump_en = 1'b1; jump_rel = 1'b0; jump_target = 5'd17;
    #2;
    check("no_comb_path", 5'd1, 1'b0, 1'b1, 1'b0, 1'b0);
    @(posedge clock);
    #1;
    check("jmp17_edge", 5'd17, 1'b0, 1'b1, 1'b0, 1'b0);
    jump_en = 1'b0;
    @(posedge clock);
    #1;
    check("seq_wrap17", 5'd18, 1'b0, 1'b1, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
